// File: rtl/bcd_counter_4digit.sv
// rtl/bcd_counter_4digit.sv - free-running multi-digit BCD counter with per-digit carry enables
module bcd_counter_4digit #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [NUM_DIGITS-1:1]     ena,
  output logic [4*NUM_DIGITS-1:0]   q
);

  logic [NUM_DIGITS-1:0] nine;
  logic [NUM_DIGITS-1:0] step;

  assign step[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nine
    assign nine[i] = (q[4*i +: 4] == 4'd9);
  end

  // A digit advances only when every lower digit is about to roll over.
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_ena
    assign ena[i]  = &nine[i-1:0];
    assign step[i] = ena[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (step[i]) begin
          q[4*i +: 4] <= nine[i] ? 4'd0 : q[4*i +: 4] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// tb/tb_bcd_counter_4digit.sv - directed and random-reset checks of bcd_counter_4digit
module tb_bcd_counter_4digit;

  logic        clk;
  logic        reset;
  logic [3:1]  ena;
  logic [15:0] q;

  int errors = 0;
  int checks = 0;
  int model  = 0;

  bcd_counter_4digit #(.NUM_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model counts in plain integers, independent of BCD arithmetic.
  always @(posedge clk or posedge reset) begin
    if (reset) model <= 0;
    else       model <= (model + 1) % 10000;
  end

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] model_ena(input int v);
    model_ena = {v % 1000 == 999, v % 100 == 99, v % 10 == 9};
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic ok;
    ok = (q[3:0] <= 9) && (q[7:4] <= 9) && (q[11:8] <= 9) && (q[15:12] <= 9);
    check({tag, "_range"}, 16'(ok), 16'd1);
    check({tag, "_q"}, q, to_bcd(model));
    check({tag, "_ena"}, 16'(ena), 16'(model_ena(model)));
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    check("rst_q", q, 16'h0000);
    check("rst_ena", 16'(ena), 16'h0);

    reset = 1'b0;
    tick(1);  check("first_q", q, 16'h0001);
    tick(8);  check("q9", q, 16'h0009);  check("q9_ena", 16'(ena), 16'h1);
    tick(1);  check("q10", q, 16'h0010); check("q10_ena", 16'(ena), 16'h0);
    tick(89); check("q99", q, 16'h0099); check("q99_ena", 16'(ena), 16'h3);
    tick(1);  check("q100", q, 16'h0100); check("q100_ena", 16'(ena), 16'h0);
    tick(9);  check("q109", q, 16'h0109); check("q109_ena", 16'(ena), 16'h1);
    tick(890); check("q999", q, 16'h0999); check("q999_ena", 16'(ena), 16'h7);
    tick(1);  check("q1000", q, 16'h1000);
    tick(8999); check("q9999", q, 16'h9999); check("q9999_ena", 16'(ena), 16'h7);
    tick(1);  check("wrap", q, 16'h0000); check("wrap_ena", 16'(ena), 16'h0);
    tick(9999); check("period_9999", q, 16'h9999);
    tick(1);  check("period_wrap", q, 16'h0000);

    tick(457); check("q457", q, 16'h0457);
    #2 reset = 1'b1;
    #1 check("async_clear", q, 16'h0000);
    #1 reset = 1'b0;
    @(posedge clk); #1 check("resume", q, 16'h0001);

    tick(20);
    @(posedge clk); reset = 1'b1;
    #1 check("edge_reset", q, 16'h0000);
    @(negedge clk); reset = 1'b0;
    tick(1); check("edge_resume", q, 16'h0001);

    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2 if ($urandom_range(31) == 0) reset = ~reset;
      @(negedge clk);
      check_model("stress");
      #2 if ($urandom_range(31) == 0) reset = ~reset;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      check_model("free");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_4digit.md
Name:
bcd_counter_4digit

Overview:
- Free-running 4-digit decimal (BCD) counter, 0000 to 9999, advancing by one every clock.
- Exposes per-digit carry-enable strobes for the upper three digits, for cascading or display logic.
- Standalone leaf block driven by the system clock and reset.

Parameters:
- NUM_DIGITS, 4, number of BCD digits.
  - q width is 4*NUM_DIGITS.
  - ena width is NUM_DIGITS-1, indexed [NUM_DIGITS-1:1].
  - Only the default value 4 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears the counter immediately.
- ena  output  3  ena[3:1]; ena[i] high means digit i increments on the next rising clk edge.
- q  output  16  BCD count.
  - q[3:0] is the ones digit, q[7:4] the tens, q[11:8] the hundreds, q[15:12] the thousands.
  - Each nibble is always in the range 0 to 9.

Behaviour:
- Reset (asynchronous, active-high):
  - While reset=1, q=16'h0000 regardless of clk.
  - q is cleared as soon as reset asserts, without waiting for a clock edge.
  - With q=0, ena=3'b000.
  - On the first rising clk edge after reset deasserts, q becomes 16'h0001.
- Counting, on every rising clk edge with reset=0:
  - Ones digit always increments; it goes from 9 to 0.
  - Digit i (i=1..3) increments only when all lower digits equal 9, i.e. when ena[i]=1. It goes from 9 to 0.
  - No enable input: the counter advances every cycle.
- ena is combinational from the current q (no register, zero latency):
  - ena[1] = (q[3:0]==9).
  - ena[2] = (q[7:0]==8'h99).
  - ena[3] = (q[11:0]==12'h999).
  - ena[1] is therefore high for 1 of every 10 cycles; ena[3] implies ena[2] implies ena[1].
- Wrap-around:
  - 16'h9999 is followed by 16'h0000; all digits roll over on the same edge.
  - At q=9999, ena=3'b111.
  - No terminal-count output and no saturation.
- Sequence and period:
  - q never holds a non-BCD nibble.
  - The sequence is strictly 0000, 0001, ... 0009, 0010, ... 9999, 0000, with period 10000 cycles.
- Reset mid-count:
  - Reset takes effect immediately from any value.
  - Counting restarts from 0000.
  - A reset pulse shorter than a clock period still clears q.
- Simultaneous reset and clock edge: reset wins, and q=0.
- Outputs are fully defined (no X) at all times after the first reset assertion.

Test Plan:
- Reset:
  - Hold reset=1 for several cycles: q=16'h0000 and ena=3'b000.
  - Release reset: after 1 edge q=0x0001; after 9 edges q=0x0009 with ena=3'b001; after 10 edges q=0x0010 with ena=3'b000.
- Tens rollover:
  - Count from reset to q=0x0099: ena=3'b011.
  - Next edge: q=0x0100 with ena=3'b000.
  - Sample q=0x0109: ena=3'b001.
- Hundreds/thousands rollover:
  - Count to q=0x0999: ena=3'b111.
  - Next edge: q=0x1000.
  - Continue to q=0x9999: ena=3'b111.
  - Next edge: q=0x0000.
  - Total period from 0000 back to 0000 is exactly 10000 cycles.
- Async reset mid-count:
  - At q=0x0457, assert reset between clock edges: q becomes 0x0000 before the next rising edge.
  - Deassert reset: the count resumes at 0x0001.
- Random reset stress:
  - Over ~400 half-cycles, toggle reset with random pulses (about 1/32 probability per half-cycle).
  - Then run 20000 free cycles.
  - Compare against a golden model: every nibble stays ≤9, ena matches its equations every cycle, and q increments by exactly one BCD step per edge when not in reset.
